// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fir_pkg
// Purpose : Shared types and width/bound helpers for the serial-MAC FIR filter.
// Revision: 1.0  initial release
// ============================================================================
package fir_pkg;

   // Controller states of the time-multiplexed filter.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } fir_state_t;

   // Accumulator width that can hold NTAPS full-scale products without overflow.
   function automatic int acc_width(input int dw, input int cw, input int ntaps);
      return dw + cw + $clog2(ntaps);
   endfunction

   // Largest value representable in an ow-bit signed output.
   function automatic longint sat_max(input int ow);
      return (longint'(1) <<< (ow - 1)) - longint'(1);
   endfunction

   // Smallest value representable in an ow-bit signed output.
   function automatic longint sat_min(input int ow);
      return -(longint'(1) <<< (ow - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/fir_round_sat.sv
`default_nettype none
// ============================================================================
// Module  : fir_round_sat
// Purpose : Round-half-up, arithmetic shift and width reduction of the
//           accumulator to the output width. With FIR_SATURATE_EN defined the
//           result is clamped to the output range and sat_hit flags a clamp;
//           otherwise the low OW bits are taken and sat_hit is 0.
// Revision: 1.0  initial release
// ============================================================================
module fir_round_sat
   import fir_pkg::*;
#(
   parameter int AW    = 35,
   parameter int OW    = 16,
   parameter int SHIFT = 15
) (
   input  logic signed [AW-1:0] acc,
   output logic signed [OW-1:0] y,
   output logic                 sat_hit
);

   // One guard bit so the rounding constant can never wrap the sum.
   localparam int RW = AW + 1;
   // Half an output LSB; zero when no shift is applied.
   localparam logic signed [RW-1:0] RND_ADD = RW'((64'd1 << SHIFT) >> 1);

   logic signed [RW-1:0] acc_ext;
   logic signed [RW-1:0] rnd_sum;
   logic signed [RW-1:0] shr;

   // Round half up, then drop SHIFT fractional bits keeping the sign.
   always_comb begin
      acc_ext = {acc[AW-1], acc};
      rnd_sum = acc_ext + RND_ADD;
      shr     = rnd_sum >>> SHIFT;
   end

`ifdef FIR_SATURATE_EN
   localparam logic signed [RW-1:0] Y_MAX = RW'(sat_max(OW));
   localparam logic signed [RW-1:0] Y_MIN = RW'(sat_min(OW));

   // Clamp to the nearest representable bound when out of range.
   always_comb begin
      y       = shr[OW-1:0];
      sat_hit = 1'b0;
      if (shr > Y_MAX) begin
         y       = Y_MAX[OW-1:0];
         sat_hit = 1'b1;
      end else if (shr < Y_MIN) begin
         y       = Y_MIN[OW-1:0];
         sat_hit = 1'b1;
      end
   end
`else
   // Upper bits are deliberately discarded by the two's-complement wrap.
   logic unused_hi;
   assign unused_hi = ^shr[RW-1:OW];

   // Keep the low OW bits; no saturation is ever reported.
   always_comb begin
      y       = shr[OW-1:0];
      sat_hit = 1'b0;
   end
`endif

endmodule
`default_nettype wire

// File: rtl/fir_serial_mac.sv
`default_nettype none
// ============================================================================
// Module  : fir_serial_mac
// Purpose : Time-multiplexed FIR filter, y[n] = sum b[k]*x[n-k], using one
//           shared multiplier over NTAPS cycles per sample. Circular delay
//           line, double-buffered coefficients, valid/ready on both sides.
//           Build option FIR_SATURATE_EN selects output saturation (applied in
//           fir_round_sat); without it the output wraps.
// Revision: 1.0  initial release
// ============================================================================
module fir_serial_mac
   import fir_pkg::*;
#(
   parameter int NTAPS = 8,
   parameter int DW    = 16,
   parameter int CW    = 16,
   parameter int OW    = 16,
   parameter int SHIFT = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DW-1:0]     in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OW-1:0]     out_data,
   input  logic                     coef_we,
   input  logic [$clog2(NTAPS)-1:0] coef_addr,
   input  logic signed [CW-1:0]     coef_data,
   input  logic                     coef_commit,
   output logic                     busy,
   output logic                     sat_flag
);

   localparam int            PW       = $clog2(NTAPS);
   localparam int            PRW      = DW + CW;
   localparam int            AW       = acc_width(DW, CW, NTAPS);
   localparam logic [PW-1:0] LAST_TAP = PW'(NTAPS - 1);
   localparam logic [PW-1:0] NT_MOD   = PW'(NTAPS);

   fir_state_t            state_q, state_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         base_q, base_d;
   logic [PW-1:0]         tap_q, tap_d;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic                  pending_q, pending_d;
   logic                  out_valid_q, out_valid_d;
   logic signed [OW-1:0]  out_data_q, out_data_d;
   logic                  sat_flag_q, sat_flag_d;

   logic signed [DW-1:0]  delay_q  [NTAPS];
   logic signed [DW-1:0]  delay_d  [NTAPS];
   logic signed [CW-1:0]  shadow_q [NTAPS];
   logic signed [CW-1:0]  shadow_d [NTAPS];
   logic signed [CW-1:0]  active_q [NTAPS];
   logic signed [CW-1:0]  active_d [NTAPS];

   logic [PW-1:0]         rd_idx;
   logic signed [PRW-1:0] coef_ext;
   logic signed [PRW-1:0] samp_ext;
   logic signed [PRW-1:0] prod;
   logic signed [AW-1:0]  prod_ext;
   logic signed [OW-1:0]  rs_data;
   logic                  rs_sat;

   // Delay-line read address (base - k) mod NTAPS and the shared product term.
   always_comb begin
      if (base_q >= tap_q) begin
         rd_idx = base_q - tap_q;
      end else begin
         rd_idx = base_q + NT_MOD - tap_q;
      end
      coef_ext = {{DW{active_q[tap_q][CW-1]}}, active_q[tap_q]};
      samp_ext = {{CW{delay_q[rd_idx][DW-1]}}, delay_q[rd_idx]};
      prod     = coef_ext * samp_ext;
      prod_ext = {{(AW-PRW){prod[PRW-1]}}, prod};
   end

   fir_round_sat #(
      .AW    (AW),
      .OW    (OW),
      .SHIFT (SHIFT)
   ) u_round_sat (
      .acc     (acc_q),
      .y       (rs_data),
      .sat_hit (rs_sat)
   );

   // Next-state logic: controller, coefficient banks, delay line, output stage.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      base_d      = base_q;
      tap_d       = tap_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      sat_flag_d  = sat_flag_q;
      pending_d   = pending_q | coef_commit;
      delay_d     = delay_q;
      shadow_d    = shadow_q;
      active_d    = active_q;

      // Shadow writes land before any same-cycle copy so the copy includes them.
      if (coef_we && (int'(coef_addr) < NTAPS)) begin
         shadow_d[coef_addr] = coef_data;
      end

      // A consumed result is cleared; OUT below may reload it in the same cycle.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_data_d  = '0;
      end

      case (state_q)
         IDLE: begin
            // Bank swap only while idle, ahead of a sample accepted this cycle.
            if (pending_d) begin
               active_d  = shadow_d;
               pending_d = 1'b0;
            end
            if (in_valid) begin
               delay_d[wr_ptr_q] = in_data;
               base_d            = wr_ptr_q;
               wr_ptr_d          = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + 1'b1;
               acc_d             = '0;
               tap_d             = '0;
               state_d           = MAC;
            end
         end
         MAC: begin
            acc_d = acc_q + prod_ext;
            if (tap_q == LAST_TAP) begin
               tap_d   = '0;
               state_d = OUT;
            end else begin
               tap_d = tap_q + 1'b1;
            end
         end
         OUT: begin
            // Wait here until the output register is free or being drained.
            if (!out_valid_q || out_ready) begin
               out_data_d  = rs_data;
               out_valid_d = 1'b1;
               sat_flag_d  = sat_flag_q | rs_sat;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous reset clearing all history and banks.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         base_q      <= '0;
         tap_q       <= '0;
         acc_q       <= '0;
         pending_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sat_flag_q  <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            delay_q[i]  <= '0;
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         base_q      <= base_d;
         tap_q       <= tap_d;
         acc_q       <= acc_d;
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         sat_flag_q  <= sat_flag_d;
         delay_q     <= delay_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign busy      = (state_q == MAC) || (state_q == OUT);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign sat_flag  = sat_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_serial_mac.sv
`default_nettype none
// ============================================================================
// Module  : tb_fir_serial_mac
// Purpose : Self-checking bench for fir_serial_mac (NTAPS=4, SHIFT=8).
//           Expected outputs come from a direct convolution over the accepted
//           sample history, queued at acceptance and compared by a monitor.
//           Honours FIR_SATURATE_EN for the expected output reduction.
// Revision: 1.0  initial release
// ============================================================================
module tb_fir_serial_mac;

   localparam int NT = 4;
   localparam int DW = 16;
   localparam int CW = 16;
   localparam int OW = 16;
   localparam int SH = 8;
   localparam longint OMAX = (longint'(1) <<< (OW - 1)) - 1;
   localparam longint OMIN = -(longint'(1) <<< (OW - 1));

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_data;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic signed [OW-1:0] out_data;
   logic                 coef_we;
   logic [1:0]           coef_addr;
   logic signed [CW-1:0] coef_data;
   logic                 coef_commit;
   logic                 busy;
   logic                 sat_flag;

   int checks = 0;
   int fails  = 0;
   int bp_mode = 0;   // 0: always ready, 1: stalled, 2: random

   // Reference model state
   longint      m_shadow [NT];
   longint      m_act    [NT];
   bit          m_pending;
   bit          m_sat;
   longint      hist [$];
   logic [OW-1:0] exp_q [$];

   // Monitor state
   bit            stall_pend;
   logic [OW-1:0] stall_data;

   fir_serial_mac #(
      .NTAPS (NT), .DW (DW), .CW (CW), .OW (OW), .SHIFT (SH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .coef_we     (coef_we),
      .coef_addr   (coef_addr),
      .coef_data   (coef_data),
      .coef_commit (coef_commit),
      .busy        (busy),
      .sat_flag    (sat_flag)
   );

   always #5 clk = ~clk;

   // Downstream ready pattern, changed just after each rising edge.
   always @(posedge clk) begin
      #1;
      case (bp_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Output monitor: hold-stability under backpressure and scoreboard pops.
   always @(negedge clk) begin
      if (rst) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            checks++;
            if (!(out_valid && out_data == stall_data)) begin
               fails++;
               $display("FAIL hold: valid=%0b data=%0d required valid=1 data=%0d",
                        out_valid, out_data, $signed(stall_data));
            end
         end
         stall_pend = out_valid && !out_ready;
         stall_data = out_data;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_output: got %0d with no sample pending", out_data);
            end else begin
               logic [OW-1:0] e;
               e = exp_q.pop_front();
               if (out_data !== e) begin
                  fails++;
                  $display("FAIL out_data: got %0d required %0d", out_data, $signed(e));
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   // Expected output from an exact sum: round half up, shift, reduce.
   function automatic logic [OW-1:0] ref_out(input longint s);
      longint r;
      r = (s + ((longint'(1) <<< SH) >>> 1)) >>> SH;
`ifdef FIR_SATURATE_EN
      if (r > OMAX) begin
         r = OMAX;
         m_sat = 1'b1;
      end else if (r < OMIN) begin
         r = OMIN;
         m_sat = 1'b1;
      end
`endif
      return r[OW-1:0];
   endfunction

   task automatic model_accept(input longint x);
      longint s;
      int n;
      if (m_pending) begin
         m_act = m_shadow;
         m_pending = 1'b0;
      end
      hist.push_back(x);
      n = hist.size() - 1;
      s = 0;
      for (int k = 0; k < NT; k++) begin
         if (n - k >= 0) s += m_act[k] * hist[n - k];
      end
      exp_q.push_back(ref_out(s));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      hist.delete();
      exp_q.delete();
      for (int k = 0; k < NT; k++) begin
         m_shadow[k] = 0;
         m_act[k] = 0;
      end
      m_pending = 1'b0;
      m_sat = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sat_flag", sat_flag, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", in_ready, 1);
   endtask

   task automatic write_coef(input int k, input int v, input bit commit);
      coef_we = 1'b1;
      coef_addr = 2'(k);
      coef_data = 16'(v);
      coef_commit = commit;
      m_shadow[k] = v;
      if (commit) m_pending = 1'b1;
      tick();
      coef_we = 1'b0;
      coef_commit = 1'b0;
   endtask

   task automatic load4(input int c0, input int c1, input int c2, input int c3,
                        input bit commit);
      write_coef(0, c0, 1'b0);
      write_coef(1, c1, 1'b0);
      write_coef(2, c2, 1'b0);
      write_coef(3, c3, commit);
   endtask

   // Present a sample until accepted; optionally commit in the accepting cycle.
   task automatic send(input int x, input bit commit);
      int n;
      in_valid = 1'b1;
      in_data = 16'(x);
      n = 0;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", in_ready, 1);
         in_valid = 1'b0;
      end else begin
         if (commit) begin
            coef_commit = 1'b1;
            m_pending = 1'b1;
         end
         model_accept(x);
         tick();
         in_valid = 1'b0;
         coef_commit = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
         tick();
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   function automatic int rnd_coef();
      return int'($urandom_range(0, 511)) - 256;
   endfunction

   function automatic int rnd_samp();
      return int'($urandom_range(0, 8191)) - 4096;
   endfunction

   initial begin
      int lat;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      coef_we = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      coef_commit = 1'b0;
      do_reset();

      // Impulse response: amplitude 1<<SH so the outputs equal the taps.
      load4(1, 2, 3, 4, 1'b1);
      send(256, 1'b0);
      repeat (4) send(0, 1'b0);
      wait_drain();

      // Latency and in_ready during processing.
      send(512, 1'b0);
      lat = 0;
      while (!out_valid && lat < 50) begin
         chk("lat_in_ready", in_ready, 0);
         tick();
         lat++;
      end
      chk("latency", lat, NT + 1);
      wait_drain();

      // Backpressure: second result waits in OUT while the first is stalled.
      bp_mode = 1;
      tick();
      send(1000, 1'b0);
      send(-700, 1'b0);
      repeat (NT + 2) tick();
      for (int i = 0; i < 20; i++) begin
         chk("bp_in_ready", in_ready, 0);
         chk("bp_busy", busy, 1);
         chk("bp_out_valid", out_valid, 1);
         tick();
      end
      bp_mode = 0;
      wait_drain();

      // Commit during MAC: current sample keeps old taps, next uses new.
      load4(5, -3, 7, 2, 1'b1);
      send(300, 1'b0);
      write_coef(0, -9, 1'b0);
      write_coef(1, 4, 1'b0);
      write_coef(2, 11, 1'b0);
      chk("commit_in_mac", busy, 1);
      write_coef(3, -6, 1'b1);
      send(-450, 1'b0);
      wait_drain();

      // Commit in the same idle cycle as an accepted sample.
      load4(20, -15, 10, 30, 1'b0);
      tick();
      send(800, 1'b1);
      send(-200, 1'b0);
      wait_drain();

      // Wrap-around: ramp of 3*NT+1 samples with random backpressure.
      load4(rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef(), 1'b1);
      bp_mode = 2;
      for (int i = 0; i < 3 * NT + 1; i++) send(i * 250 - 1500, 1'b0);

      // Random samples with occasional coefficient reloads and idle gaps.
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 4) == 0)
            load4(rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef(), 1'b1);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) tick();
         send(rnd_samp(), 1'b0);
      end
      bp_mode = 0;
      wait_drain();
      chk("sat_flag_clear", sat_flag, m_sat);

      // Saturation: full-scale taps and inputs of both signs.
      load4(32767, 32767, 32767, 32767, 1'b1);
      repeat (4) send(32767, 1'b0);
      repeat (4) send(-32768, 1'b0);
      wait_drain();
      chk("sat_flag", sat_flag, m_sat);

      // Reset in the middle of MAC: the sample is dropped.
      send(1234, 1'b0);
      tick();
      chk("mid_mac_busy", busy, 1);
      do_reset();
      for (int i = 0; i < 10; i++) begin
         chk("abort_no_output", out_valid, 0);
         tick();
      end

      // Zero-history impulse after reset.
      load4(1, 2, 3, 4, 1'b1);
      send(256, 1'b0);
      repeat (4) send(0, 1'b0);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
